// File: rtl/lisa_qspi_arb.sv
// Two-requester arbiter in front of a single QSPI controller: instruction fetch
// versus data, round-robin on contention, with enforced chip-select idle gap.
module lisa_qspi_arb #(
   parameter int unsigned CS_GAP = 2,
   parameter int unsigned ADDR_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              ack0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              we1,
   input  logic [7:0]        wdata1,
   output logic              ack1,
   output logic              err1,
   output logic [7:0]        rdata,
   output logic              ctrl_start,
   output logic [ADDR_W-1:0] ctrl_addr,
   output logic              ctrl_we,
   output logic [7:0]        ctrl_wdata,
   output logic              ctrl_cs_sel,
   input  logic              ctrl_done,
   input  logic [7:0]        ctrl_rdata,
   output logic [1:0]        grant
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam logic [3:0] GAP_LOAD = CS_GAP[3:0];

   state_t            state_r, state_s;
   logic [3:0]        gap_cnt_r, gap_cnt_s;
   logic              last_data_r, last_data_s;
   logic              busy_ack_s, win_fetch_s, win_data_s, reject_s;
   logic              ack0_s, ack1_s, err1_s, ctrl_start_s, ctrl_we_s, ctrl_cs_sel_s;
   logic [7:0]        rdata_s, ctrl_wdata_s;
   logic [ADDR_W-1:0] ctrl_addr_s;
   logic [1:0]        grant_s;

   // Arbitration: no new grant while an ack is on the bus, so a requester that
   // is only just seeing its ack is not served twice.
   always_comb begin
      busy_ack_s  = ack0 | ack1;
      win_fetch_s = req0 & (~req1 | last_data_r);
      win_data_s  = req1 & (~req0 | ~last_data_r);
      reject_s    = win_data_s & we1 & ~addr1[ADDR_W-1];
   end

   // Next-state and next-output logic for the arbiter FSM.
   always_comb begin
      state_s       = state_r;
      gap_cnt_s     = gap_cnt_r;
      last_data_s   = last_data_r;
      grant_s       = grant;
      ctrl_start_s  = 1'b0;
      ack0_s        = 1'b0;
      ack1_s        = 1'b0;
      err1_s        = 1'b0;
      rdata_s       = rdata;
      ctrl_addr_s   = ctrl_addr;
      ctrl_we_s     = ctrl_we;
      ctrl_wdata_s  = ctrl_wdata;
      ctrl_cs_sel_s = ctrl_cs_sel;
      case (state_r)
         IDLE: begin
            if (!busy_ack_s && win_fetch_s) begin
               ctrl_addr_s   = addr0;
               ctrl_we_s     = 1'b0;
               ctrl_wdata_s  = 8'h00;
               ctrl_cs_sel_s = 1'b0;
               grant_s       = 2'b01;
               last_data_s   = 1'b0;
               ctrl_start_s  = 1'b1;
               state_s       = ISSUE;
            end else if (!busy_ack_s && reject_s) begin
               ack1_s      = 1'b1;
               err1_s      = 1'b1;
               last_data_s = 1'b1;
               state_s     = IDLE;
            end else if (!busy_ack_s && win_data_s) begin
               ctrl_addr_s   = addr1;
               ctrl_we_s     = we1;
               ctrl_wdata_s  = wdata1;
               ctrl_cs_sel_s = addr1[ADDR_W-1];
               grant_s       = 2'b10;
               last_data_s   = 1'b1;
               ctrl_start_s  = 1'b1;
               state_s       = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            state_s = WAIT;
         end
         WAIT: begin
            if (ctrl_done) begin
               rdata_s = ctrl_rdata;
               ack0_s  = grant[0];
               ack1_s  = grant[1];
               grant_s = 2'b00;
               if (GAP_LOAD == 4'd0) begin
                  state_s = IDLE;
               end else begin
                  gap_cnt_s = GAP_LOAD;
                  state_s   = GAP;
               end
            end else begin
               state_s = WAIT;
            end
         end
         GAP: begin
            if (gap_cnt_r <= 4'd1) begin
               gap_cnt_s = 4'd0;
               state_s   = IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r - 4'd1;
               state_s   = GAP;
            end
         end
         default: begin
            state_s = IDLE;
            grant_s = 2'b00;
         end
      endcase
   end

   // State and registered-output update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         gap_cnt_r   <= 4'd0;
         last_data_r <= 1'b1;
         grant       <= 2'b00;
         ctrl_start  <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         err1        <= 1'b0;
         rdata       <= 8'h00;
         ctrl_addr   <= {ADDR_W{1'b0}};
         ctrl_we     <= 1'b0;
         ctrl_wdata  <= 8'h00;
         ctrl_cs_sel <= 1'b0;
      end else begin
         state_r     <= state_s;
         gap_cnt_r   <= gap_cnt_s;
         last_data_r <= last_data_s;
         grant       <= grant_s;
         ctrl_start  <= ctrl_start_s;
         ack0        <= ack0_s;
         ack1        <= ack1_s;
         err1        <= err1_s;
         rdata       <= rdata_s;
         ctrl_addr   <= ctrl_addr_s;
         ctrl_we     <= ctrl_we_s;
         ctrl_wdata  <= ctrl_wdata_s;
         ctrl_cs_sel <= ctrl_cs_sel_s;
      end
   end

endmodule
